// File: rtl/coherence_bus_arbiter.sv
// Two-core memory bus arbiter with snoop sequencing and cache-to-cache transfer.
// Define COHERENCE_BUS_RR_EN for per-class round-robin; otherwise core 0 always wins.
`timescale 1ns/1ps
module coherence_bus_arbiter (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic             ramready
);

  typedef enum logic [2:0] {S_IDLE, S_INV, S_SNOOP, S_DRD, S_C2C, S_DWR, S_IRD} state_t;

  state_t     r_state, w_next;
  logic       r_g, w_next_g;
  logic       w_o, w_pd, w_pi;
  logic [1:0] w_inv;

  assign w_o   = ~r_g;
  assign w_inv = cctrans & ccwrite & ~dREN & ~dWEN;

  function automatic logic pick(input logic [1:0] mask, input logic ptr);
    return mask[ptr] ? ptr : ~ptr;
  endfunction

`ifdef COHERENCE_BUS_RR_EN
  logic r_ptr_d, r_ptr_i;
  assign w_pd = r_ptr_d;
  assign w_pi = r_ptr_i;

  // Any ack hands priority in that class to the other core.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr_d <= 1'b0;
      r_ptr_i <= 1'b0;
    end else begin
      if (dwait != 2'b11) r_ptr_d <= ~r_g;
      if (iwait != 2'b11) r_ptr_i <= ~r_g;
    end
  end
`else
  assign w_pd = 1'b0;
  assign w_pi = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_g     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_g     <= w_next_g;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_next_g    = r_g;
    iwait       = 2'b11;
    dwait       = 2'b11;
    iload       = '0;
    dload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_inv != 2'b00) begin
          w_next   = S_INV;
          w_next_g = pick(w_inv, w_pd);
        end else if (dWEN != 2'b00) begin
          w_next   = S_DWR;
          w_next_g = pick(dWEN, w_pd);
        end else if (dREN != 2'b00) begin
          w_next   = S_SNOOP;
          w_next_g = pick(dREN, w_pd);
        end else if (iREN != 2'b00) begin
          w_next   = S_IRD;
          w_next_g = pick(iREN, w_pi);
        end
      end
      S_INV: begin
        ccwait[w_o]      = 1'b1;
        ccinv[w_o]       = 1'b1;
        ccsnoopaddr[w_o] = daddr[r_g];
        dwait[r_g]       = 1'b0;
        w_next           = S_IDLE;
      end
      S_DWR: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r_g];
        ramstore = dstore[r_g];
        if (!dWEN[r_g]) begin
          w_next = S_IDLE;
        end else if (ramready) begin
          dwait[r_g] = 1'b0;
          w_next     = S_IDLE;
        end
      end
      S_SNOOP: begin
        ccwait[w_o]      = 1'b1;
        ccinv[w_o]       = cctrans[r_g];
        ccsnoopaddr[w_o] = daddr[r_g];
        w_next           = ccwrite[w_o] ? S_C2C : S_DRD;
      end
      S_DRD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[r_g];
        if (!dREN[r_g]) begin
          w_next = S_IDLE;
        end else if (ramready) begin
          dload[r_g] = ramload;
          dwait[r_g] = 1'b0;
          w_next     = S_IDLE;
        end
      end
      S_C2C: begin
        // Modified line comes from the snooper and is written back to RAM at once.
        ccwait[w_o]      = 1'b1;
        ccinv[w_o]       = cctrans[r_g];
        ccsnoopaddr[w_o] = daddr[r_g];
        dload[r_g]       = dstore[w_o];
        ramWEN           = 1'b1;
        ramaddr          = daddr[r_g];
        ramstore         = dstore[w_o];
        if (!dREN[r_g]) begin
          w_next = S_IDLE;
        end else if (ramready) begin
          dwait[r_g] = 1'b0;
          w_next     = S_IDLE;
        end
      end
      S_IRD: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[r_g];
        if (!iREN[r_g]) begin
          w_next = S_IDLE;
        end else if (ramready) begin
          iload[r_g] = ramload;
          iwait[r_g] = 1'b0;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
